scl_clk_gen: RTL

Parametrised, runtime-programmable clock generator; next generation of the fixed 100 kHz divider that feeds the camera SCCB/I2C master.
- Derives a slow divided clock (clk_o) from the system clock.
- Emits single-cycle phase strobes at period start, mid-low, rising edge and mid-high. The serial master uses these to change SDA (mid-low) and sample SDA (mid-high).
- Supports divisor reload at period boundaries, a configurable idle level and a clean stop that always finishes the current period.

---
 rtl/scl_clk_pkg.sv | 12 +
 rtl/scl_clk_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/scl_clk_pkg.sv
// Shared types and constants for the SCL clock generator.
package scl_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    localparam int MIN_DIV = 4;

endpackage

// File: rtl/scl_clk_gen.sv
// Runtime-programmable SCL clock divider with phase strobes, period-boundary
// divisor reload and a stop request that always completes the current period.
module scl_clk_gen #(
    parameter int   DIV_W       = 16,
    parameter int   DEFAULT_DIV = 1000,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             clk_o,
    output logic             fall_tick_o,
    output logic             mid_low_tick_o,
    output logic             rise_tick_o,
    output logic             mid_high_tick_o,
    output logic             busy_o,
    output logic             div_err_o
);
    import scl_clk_pkg::*;

    localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

    if ((DEFAULT_DIV < MIN_DIV) || ((DEFAULT_DIV >> DIV_W) != 0)) begin : g_bad_default_div
        $error("scl_clk_gen: DEFAULT_DIV outside 4 .. 2^DIV_W-1");
    end

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;

    logic             clk_q, clk_d;
    logic             fall_q, fall_d;
    logic             mid_low_q, mid_low_d;
    logic             rise_q, rise_d;
    logic             mid_high_q, mid_high_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             load_ok_s;
    logic             wrap_s;
    logic             run_next_s;
    logic [DIV_W-1:0] hi_len_s;
    logic [DIV_W-1:0] lo_len_s;

    // Next-state: counter, divisor/pending handling and run/stop sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        load_ok_s  = div_load_i && (div_i >= MIN_DIV_V);
        wrap_s     = (state_q != IDLE) && (cnt_q == (div_q - DIV_W'(1)));

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                pend_vld_d = 1'b0;
                if (load_ok_s) begin
                    div_d = div_i;
                end else if (pend_vld_q) begin
                    div_d = pend_q;
                end else begin
                    div_d = div_q;
                end
                if (en_i) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, STOPPING: begin
                // Pending value from earlier cycles applies at this wrap;
                // a load arriving now waits for the following wrap.
                if (wrap_s) begin
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        div_d = pend_q;
                    end else begin
                        div_d = div_q;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (load_ok_s) begin
                    pend_d     = div_i;
                    pend_vld_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (state_q == RUN) begin
                    state_d = en_i ? RUN : STOPPING;
                end else if (en_i) begin
                    state_d = RUN;
                end else if (wrap_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOPPING;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                pend_vld_d = 1'b0;
            end
        endcase
    end

    // Phase decode of the upcoming cycle so every output is registered.
    always_comb begin
        run_next_s = (state_d != IDLE);
        hi_len_s   = div_d >> 1;
        lo_len_s   = div_d - hi_len_s;
        if (run_next_s) begin
            clk_d      = (cnt_d >= lo_len_s);
            fall_d     = (cnt_d == '0);
            mid_low_d  = (cnt_d == (lo_len_s >> 1));
            rise_d     = (cnt_d == lo_len_s);
            mid_high_d = (cnt_d == (lo_len_s + (hi_len_s >> 1)));
        end else begin
            clk_d      = IDLE_LEVEL;
            fall_d     = 1'b0;
            mid_low_d  = 1'b0;
            rise_d     = 1'b0;
            mid_high_d = 1'b0;
        end
        busy_d = run_next_s;
        err_d  = div_load_i && (div_i < MIN_DIV_V);
    end

    // State, counter, divisor and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEF_DIV;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= IDLE_LEVEL;
            fall_q     <= 1'b0;
            mid_low_q  <= 1'b0;
            rise_q     <= 1'b0;
            mid_high_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            fall_q     <= fall_d;
            mid_low_q  <= mid_low_d;
            rise_q     <= rise_d;
            mid_high_q <= mid_high_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign clk_o           = clk_q;
    assign fall_tick_o     = fall_q;
    assign mid_low_tick_o  = mid_low_q;
    assign rise_tick_o     = rise_q;
    assign mid_high_tick_o = mid_high_q;
    assign busy_o          = busy_q;
    assign div_err_o       = err_q;

endmodule
